// File: rtl/bru_pkg.sv
// Shared types, widths and the target-address check for the branch redirect controller.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable; pipe_stall handling lives in branch_redirect_ctrl.
package bru_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REDIRECT,
    SQUASH
  } bru_state_t;

  // Squash counter width; covers FLUSH_DEPTH up to 7.
  localparam int FLUSH_CNT_W = 3;

  // A target is bad when it is not word aligned or lies above the fetch address space.
  function automatic logic bru_addr_err(input logic [31:0] br_pc, input int unsigned pc_w);
    logic [31:0] hi;
    hi = br_pc >> pc_w;
    return (br_pc[1:0] != 2'b00) || (hi != 32'd0);
  endfunction

endpackage

// File: rtl/bru_sat_counter.sv
// Saturating event counter for redirect statistics; sticks at all-ones.
// Latency: count reflects an increment one cycle after inc is sampled.
// Backpressure: none; inc is sampled every cycle, clr has priority over inc.
module bru_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Count up on inc until all-ones, synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Sequences EX-resolved taken branches into a one-cycle PC redirect plus wrong-path squash.
// Latency: capture in cycle N without stall -> redirect_valid in N+1; flush_if_id lasts FLUSH_DEPTH cycles.
// Backpressure: pipe_stall holds a captured target in HOLD and freezes the squash count; no timeout.
// Optional statistics counters are built only when BRU_STATS_EN is defined.
module branch_redirect_ctrl
  import bru_pkg::*;
#(
  parameter int PC_W        = 9,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_pc_sel,
  input  logic [31:0]      ex_br_pc,
  input  logic             pipe_stall,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             addr_err,
  output logic             busy,
  output logic [CNT_W-1:0] stat_taken,
  output logic [CNT_W-1:0] stat_dropped
);

  bru_state_t             state, state_nxt;
  logic [FLUSH_CNT_W-1:0] cnt, cnt_nxt;
  logic                   err_flag;
  logic                   capture;
  logic                   capture_ld;

  assign capture = ex_valid & ex_pc_sel;
  assign busy    = (state != IDLE);

  // State, squash counter and latched target; reset drops any pending redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      redirect_pc <= '0;
      err_flag    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture_ld) begin
        redirect_pc <= {ex_br_pc[PC_W-1:2], 2'b00};
        err_flag    <= bru_addr_err(ex_br_pc, PC_W);
      end
    end
  end

  // Next state and Moore outputs; events outside IDLE are wrong-path and ignored.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    capture_ld     = 1'b0;
    redirect_valid = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_ex    = 1'b0;
    addr_err       = 1'b0;
    case (state)
      IDLE: begin
        if (capture) begin
          capture_ld = 1'b1;
          state_nxt  = pipe_stall ? HOLD : REDIRECT;
        end
      end
      HOLD: begin
        if (!pipe_stall) begin
          state_nxt = REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        flush_if_id    = 1'b1;
        flush_id_ex    = 1'b1;
        addr_err       = err_flag;
        if (FLUSH_DEPTH == 1) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = SQUASH;
          cnt_nxt   = FLUSH_CNT_W'(FLUSH_DEPTH - 1);
        end
      end
      SQUASH: begin
        flush_if_id = 1'b1;
        if (!pipe_stall) begin
          cnt_nxt = cnt - FLUSH_CNT_W'(1);
          if (cnt == FLUSH_CNT_W'(1)) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef BRU_STATS_EN
  logic taken_inc;
  logic drop_inc;

  // A redirect is counted on the edge that enters REDIRECT.
  assign taken_inc = (state_nxt == REDIRECT) && (state != REDIRECT);
  assign drop_inc  = capture && (state != IDLE);

  bru_sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .inc   (taken_inc),
    .clr   (reset),
    .count (stat_taken)
  );

  bru_sat_counter #(.CNT_W(CNT_W)) u_dropped_cnt (
    .clk   (clk),
    .inc   (drop_inc),
    .clr   (reset),
    .count (stat_dropped)
  );
`else
  assign stat_taken   = '0;
  assign stat_dropped = '0;
`endif

endmodule
